// File: rtl/pio_input_conditioner.sv
// Raw board input conditioner for a 1-bit PIO: synchronizer, debounce, polarity, edge/event flags.
// Optional FALL_DETECT_EN macro adds fall_pulse / fall_flag release-event outputs.
module pio_input_conditioner #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw_in,
    input  logic ack,
    output logic level_out,
    output logic rise_pulse,
    output logic event_flag,
`ifdef FALL_DETECT_EN
    output logic fall_pulse,
    output logic fall_flag,
`endif
    output logic busy
);

    localparam logic IDLE_RAW = (ACTIVE_LOW != 0);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    // With a one-cycle debounce the counter never needs to leave 0.
    localparam logic [CNT_W-1:0] CNT_FIRST = (DEBOUNCE_CYCLES > 1) ? CNT_W'(1) : '0;

    typedef enum logic {
        STABLE,
        QUALIFY
    } state_t;

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   norm_in;
    state_t                 state_reg;
    logic [CNT_W-1:0]       cnt_reg;
    logic                   level_reg;
    logic                   rise_reg;
    logic                   event_reg;
    logic                   busy_reg;
    logic                   fall_reg;
    logic                   fall_flag_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_reg <= {SYNC_STAGES{IDLE_RAW}};
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], raw_in};
        end
    end

    assign norm_in = sync_reg[SYNC_STAGES-1] ^ IDLE_RAW;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= STABLE;
            cnt_reg       <= '0;
            level_reg     <= 1'b0;
            rise_reg      <= 1'b0;
            event_reg     <= 1'b0;
            busy_reg      <= 1'b0;
            fall_reg      <= 1'b0;
            fall_flag_reg <= 1'b0;
        end else begin
            rise_reg <= 1'b0;
            fall_reg <= 1'b0;
            // Ack clears first so a same-edge set below takes priority.
            if (ack) begin
                event_reg     <= 1'b0;
                fall_flag_reg <= 1'b0;
            end
            case (state_reg)
                STABLE: begin
                    cnt_reg  <= '0;
                    busy_reg <= 1'b0;
                    if (norm_in != level_reg) begin
                        cnt_reg   <= CNT_FIRST;
                        busy_reg  <= 1'b1;
                        state_reg <= QUALIFY;
                    end
                end
                QUALIFY: begin
                    if (norm_in == level_reg) begin
                        cnt_reg   <= '0;
                        busy_reg  <= 1'b0;
                        state_reg <= STABLE;
                    end else if (cnt_reg == CNT_LAST || DEBOUNCE_CYCLES == 1) begin
                        level_reg <= ~level_reg;
                        if (!level_reg) begin
                            rise_reg  <= 1'b1;
                            event_reg <= 1'b1;
                        end else begin
                            fall_reg      <= 1'b1;
                            fall_flag_reg <= 1'b1;
                        end
                        cnt_reg   <= '0;
                        busy_reg  <= 1'b0;
                        state_reg <= STABLE;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                default: begin
                    cnt_reg   <= '0;
                    busy_reg  <= 1'b0;
                    state_reg <= STABLE;
                end
            endcase
        end
    end

    assign level_out  = level_reg;
    assign rise_pulse = rise_reg;
    assign event_flag = event_reg;
    assign busy       = busy_reg;

`ifdef FALL_DETECT_EN
    assign fall_pulse = fall_reg;
    assign fall_flag  = fall_flag_reg;
`else
    logic unused_fall;
    assign unused_fall = fall_reg ^ fall_flag_reg;
`endif

endmodule
